eedc_encode: RTL and testbench
==============================

Name: eedc_encode

Overview:
- Streaming encoder stage, directly upstream of the EEDC decoder.
- Accepts 7-bit data words over a valid/ready handshake and produces 11-bit codewords: 4 check bits plus the data.
- Optional one-shot single-bit error injection feeds the downstream decoder's correction path in system tests.
- 2-entry output buffer keeps downstream backpressure from stalling the producer for one cycle.

Parameters:
- CNT_W, 16, width of the wrapping word and injection counters.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  7  payload word
- in_valid  input  1  data_in is valid
- in_ready  output  1  block can accept a word this cycle
- encoded_output  output  11  codeword at FIFO head
- out_valid  output  1  encoded_output is valid
- out_ready  input  1  downstream accepts this cycle
- inj_arm  input  1  pulse: arm a one-shot bit flip
- inj_pos  input  4  codeword bit index to flip, 0..10
- inj_pending  output  1  injection armed, not yet applied
- word_count  output  CNT_W  codewords delivered (out_valid & out_ready)
- inj_count  output  CNT_W  codewords delivered with an injected flip

Behaviour:
- Codeword layout, with d = data_in:
  - code[10:4] = d[6:0]
  - code[3] = d6^d4^d2^d0
  - code[2] = d5^d4^d1^d0
  - code[1] = d3^d2^d1^d0
  - code[0] = XOR of code[10:1] (overall even parity)
- Encoding is combinational on acceptance; the FIFO stores the finished codeword, after any injection.
- Accept = in_valid & in_ready; deliver = out_valid & out_ready.
- FIFO: 2 entries, occupancy cnt 0..2. in_ready = (cnt != 2), derived from registers only. out_valid = (cnt != 0).
- Latency: a word accepted in cycle N with cnt==0 is on encoded_output with out_valid=1 in cycle N+1.
- Simultaneous accept and deliver at cnt==1: cnt stays 1; the new word becomes head in the next cycle.
- At cnt==2, no accept occurs regardless of in_valid.
- encoded_output holds stable while out_valid & !out_ready. With out_valid=0 the value is don't-care but must not be X after reset.
- Injection:
  - inj_arm=1 with inj_pos<=10 sets inj_pending and latches the position.
  - inj_arm with inj_pos>10 is ignored.
  - The first accepted word while pending is stored with bit[pos] inverted; pending clears in that same cycle.
  - inj_arm coinciding with an accept does not affect the word accepted in that cycle.
  - Re-arming while pending overwrites the position.
- Each FIFO entry carries an injected flag. inj_count increments on delivery of a flagged entry.
- Both counters wrap modulo 2^CNT_W.
- Reset, also taking effect mid-transfer: cnt=0, in_ready=0 during the reset cycle and 1 after, out_valid=0, encoded_output=0, inj_pending=0, both counters 0. Buffered words are discarded.

Decomposition:
- Shared package eedc_pkg holds:
  - DATA_W=7, CODE_W=11
  - parity bit index constants P0..P3
  - a pure encode function, so the decoder and the bench reuse identical equations.
- One natural sub-module: eedc_fifo2, a 2-entry valid/ready buffer carrying {injected flag, codeword}.
- The encoder top holds the injection logic and the counters.

Test Plan:
- Reset then data_in=7'h01, in_valid for 1 cycle, out_ready=1 -> next cycle out_valid=1, encoded_output=11'h01E; word_count=1 after delivery.
- data_in 7'h7F then 7'h40, back-to-back, out_ready=1 -> outputs 11'h7F1 then 11'h408 on consecutive cycles; in_ready stays 1 throughout.
- out_ready=0, push 3 words -> in_ready drops after the 2nd accept, third word held. Then out_ready=1 -> all 3 delivered in order, no loss or duplication.
- inj_arm with inj_pos=10, then send 7'h7F -> 11'h3F1, inj_pending clears on accept, inj_count=1. The next 7'h7F -> 11'h7F1.
- inj_arm with inj_pos=12 -> inj_pending stays 0 and the codeword is unmodified.
- rst asserted while cnt==2 and out_ready=0 -> next cycle out_valid=0, counters 0; a subsequent word encodes correctly.

Source files
------------

// File: rtl/eedc_pkg.sv
// Shared EEDC constants and the codeword equations used by the encoder, decoder and bench.
package eedc_pkg;
  localparam int DATA_W = 7;
  localparam int CODE_W = 11;
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c = '0;
    c[CODE_W-1:4] = d;
    c[P3] = d[6] ^ d[4] ^ d[2] ^ d[0];
    c[P2] = d[5] ^ d[4] ^ d[1] ^ d[0];
    c[P1] = d[3] ^ d[2] ^ d[1] ^ d[0];
    // c[P0] is still 0 here, so this is the even parity of bits 10..1
    c[P0] = ^c;
    return c;
  endfunction
endpackage

// File: rtl/eedc_fifo2.sv
// Two-entry valid/ready buffer; head is always held in head_q so the output is a plain register.
module eedc_fifo2
  import eedc_pkg::*;
#(
  parameter int W = CODE_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         ready_q, ready_d;
  logic         push, pop;

  assign in_ready  = ready_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      // push and pop together only happen with one entry held
      2'b11: head_d = in_data;
      default: ;
    endcase
    ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  end
endmodule

// File: rtl/eedc_encode.sv
// EEDC encoder: encodes accepted words, applies optional one-shot bit flips, counts deliveries.
module eedc_encode
  import eedc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [10:0]       encoded_output,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              inj_arm,
  input  logic [3:0]        inj_pos,
  output logic              inj_pending,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  inj_count
);
  logic              pending_q, pending_d;
  logic [3:0]        pos_q, pos_d;
  logic [CNT_W-1:0]  wc_q, wc_d;
  logic [CNT_W-1:0]  ic_q, ic_d;
  logic              accept, deliver, arm_ok, inj_now;
  logic [CODE_W-1:0] code;
  logic [CODE_W:0]   fifo_out;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;
  assign arm_ok  = inj_arm & (inj_pos <= 4'(CODE_W - 1));
  assign inj_now = accept & pending_q;

  always_comb begin
    code = encode(data_in);
    if (inj_now) code = code ^ (CODE_W'(1) << pos_q);
  end

  // a new arm in the same cycle as an injection re-arms for the following word
  always_comb begin
    pending_d = pending_q;
    pos_d     = pos_q;
    if (inj_now) pending_d = 1'b0;
    if (arm_ok) begin
      pending_d = 1'b1;
      pos_d     = inj_pos;
    end
    wc_d = wc_q + (deliver ? CNT_W'(1) : CNT_W'(0));
    ic_d = ic_q + ((deliver & fifo_out[CODE_W]) ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      pos_q     <= 4'd0;
      wc_q      <= '0;
      ic_q      <= '0;
    end else begin
      pending_q <= pending_d;
      pos_q     <= pos_d;
      wc_q      <= wc_d;
      ic_q      <= ic_d;
    end
  end

  eedc_fifo2 #(.W(CODE_W + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({inj_now, code}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (fifo_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign encoded_output = fifo_out[CODE_W-1:0];
  assign inj_pending    = pending_q;
  assign word_count     = wc_q;
  assign inj_count      = ic_q;
endmodule

// File: tb/tb_eedc_encode.sv
// Directed bench for eedc_encode with a queue-based reference model checked every cycle.
module tb_eedc_encode;
  logic        clk;
  logic        rst;
  logic [6:0]  data_in;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] encoded_output;
  logic        out_valid;
  logic        out_ready;
  logic        inj_arm;
  logic [3:0]  inj_pos;
  logic        inj_pending;
  logic [15:0] word_count;
  logic [15:0] inj_count;

  int checks = 0;
  int errors = 0;

  eedc_encode #(.CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .encoded_output (encoded_output),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .inj_arm        (inj_arm),
    .inj_pos        (inj_pos),
    .inj_pending    (inj_pending),
    .word_count     (word_count),
    .inj_count      (inj_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // codeword from parity masks over the data word
  function automatic logic [10:0] mcode(input logic [6:0] d);
    logic p3, p2, p1, p0;
    p3 = ^(d & 7'b1010101);
    p2 = ^(d & 7'b0110011);
    p1 = ^(d & 7'b0001111);
    p0 = ^{d, p3, p2, p1};
    return {d, p3, p2, p1, p0};
  endfunction

  typedef struct {
    logic [10:0] code;
    bit          flag;
  } ent_t;

  ent_t        mq[$];
  bit          mvalid = 0;
  bit          rst_last = 0;
  bit          pend = 0;
  logic [3:0]  mpos = 4'd0;
  logic [15:0] wc = 16'd0;
  logic [15:0] ic = 16'd0;

  always @(negedge clk) begin
    bit exp_ready, acc, dlv;
    ent_t e;
    exp_ready = !rst_last && (mq.size() != 2);
    if (mvalid) begin
      check("m_out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) check("m_encoded_output", encoded_output, mq[0].code);
      check("m_enc_known", !$isunknown(encoded_output), 1);
      check("m_in_ready", in_ready, exp_ready);
      check("m_inj_pending", inj_pending, pend);
      check("m_word_count", word_count, wc);
      check("m_inj_count", inj_count, ic);
    end
    if (rst) begin
      mq.delete();
      pend = 0;
      wc = 16'd0;
      ic = 16'd0;
      rst_last = 1;
      mvalid = 1;
    end else if (mvalid) begin
      acc = in_valid && exp_ready;
      dlv = (mq.size() != 0) && out_ready;
      e.code = mcode(data_in);
      e.flag = 0;
      if (acc && pend) begin
        e.code[mpos] = ~e.code[mpos];
        e.flag = 1;
        pend = 0;
      end
      if (dlv) begin
        wc = wc + 16'd1;
        if (mq[0].flag) ic = ic + 16'd1;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(e);
      if (inj_arm && inj_pos <= 4'd10) begin
        pend = 1;
        mpos = inj_pos;
      end
      rst_last = 0;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] d, input logic ordy);
    in_valid  = v;
    data_in   = d;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1;
    inj_arm = 1'b0;
    inj_pos = 4'd0;
    drive(0, 7'h00, 1);
    cycle();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_enc", encoded_output, 11'h000);
    check("rst_wc", word_count, 0);
    cycle();
    rst = 1'b0;
    cycle();
    check("post_rst_in_ready", in_ready, 1);
    $display("reset released");

    drive(1, 7'h01, 1); cycle();
    drive(0, 7'h00, 1);
    check("t1_valid", out_valid, 1);
    check("t1_enc", encoded_output, 11'h01E);
    cycle();
    check("t1_wc", word_count, 1);
    $display("txn 7'h01 -> %h", 11'h01E);

    drive(1, 7'h7F, 1); cycle();
    drive(1, 7'h40, 1);
    check("t2_enc0", encoded_output, 11'h7F1);
    check("t2_rdy0", in_ready, 1);
    cycle();
    drive(0, 7'h00, 1);
    check("t2_enc1", encoded_output, 11'h408);
    check("t2_rdy1", in_ready, 1);
    cycle();
    check("t2_wc", word_count, 3);
    $display("txn 7'h7F,7'h40 back-to-back");

    drive(1, 7'h11, 0); cycle();
    drive(1, 7'h22, 0); cycle();
    check("t3_full", in_ready, 0);
    drive(1, 7'h33, 0); cycle();
    check("t3_held", in_ready, 0);
    check("t3_head", encoded_output, 11'h113);
    drive(1, 7'h33, 1); cycle();
    check("t3_second", encoded_output, mcode(7'h22));
    cycle();
    drive(0, 7'h00, 1);
    check("t3_third", encoded_output, mcode(7'h33));
    cycle();
    check("t3_empty", out_valid, 0);
    check("t3_wc", word_count, 6);
    $display("txn backpressure 3 words");

    inj_arm = 1'b1; inj_pos = 4'd10; cycle();
    inj_arm = 1'b0;
    check("t4_pend", inj_pending, 1);
    drive(1, 7'h7F, 1); cycle();
    check("t4_clr", inj_pending, 0);
    check("t4_enc", encoded_output, 11'h3F1);
    cycle();
    drive(0, 7'h00, 1);
    check("t4_enc2", encoded_output, 11'h7F1);
    check("t4_ic", inj_count, 1);
    cycle();
    $display("txn inject pos10");

    inj_arm = 1'b1; inj_pos = 4'd12; cycle();
    inj_arm = 1'b0;
    check("t5_pend", inj_pending, 0);
    drive(1, 7'h7F, 1); cycle();
    drive(0, 7'h00, 1);
    check("t5_enc", encoded_output, 11'h7F1);
    cycle();
    check("t5_ic", inj_count, 1);
    $display("txn inject pos12 ignored");

    inj_arm = 1'b1; inj_pos = 4'd3; cycle();
    inj_pos = 4'd0;
    drive(1, 7'h00, 1); cycle();
    inj_arm = 1'b0;
    check("t6_enc", encoded_output, 11'h008);
    check("t6_rearm", inj_pending, 1);
    cycle();
    drive(0, 7'h00, 1);
    check("t6_enc2", encoded_output, 11'h001);
    check("t6_pend", inj_pending, 0);
    cycle();
    check("t6_ic", inj_count, 3);
    $display("txn re-arm during accept");

    drive(1, 7'h55, 0); cycle();
    cycle();
    rst = 1'b1; cycle();
    check("t7_valid", out_valid, 0);
    check("t7_wc", word_count, 0);
    check("t7_ic", inj_count, 0);
    check("t7_rdy", in_ready, 0);
    check("t7_enc", encoded_output, 11'h000);
    rst = 1'b0;
    drive(0, 7'h00, 1); cycle();
    check("t7_rdy2", in_ready, 1);
    drive(1, 7'h01, 1); cycle();
    drive(0, 7'h00, 1);
    check("t7_enc2", encoded_output, 11'h01E);
    cycle();
    check("t7_wc2", word_count, 1);
    $display("txn reset while full");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
